// File: rtl/periph_apb_arb_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
package periph_apb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } arb_state_e;

  typedef logic req_idx_t;

  localparam int unsigned TIMEOUT_RDATA = 0;

endpackage

// File: rtl/apb_rr_arbiter2.sv
// Combinational two-way round-robin pick; the caller owns the last-grant register.
module apb_rr_arbiter2
  import periph_apb_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_idx_t   last_grant_i,
  output req_idx_t   gnt_idx_o,
  output logic       valid_o
);

  always_comb begin
    valid_o   = |req_i;
    gnt_idx_o = last_grant_i;
    case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_grant_i;
      default: gnt_idx_o = last_grant_i;
    endcase
  end

endmodule

// File: rtl/periph_apb_arbiter.sv
// Two-requester APB arbiter: round-robin grant, locally sequenced setup/access
// phases and an access-phase timeout that aborts with PSLVERR.
module periph_apb_arbiter
  import periph_apb_arb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_CNT_WIDTH   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      s0_psel,
  input  logic                      s0_penable,
  input  logic                      s0_pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] s0_paddr,
  input  logic [APB_DATA_WIDTH-1:0] s0_pwdata,
  output logic [APB_DATA_WIDTH-1:0] s0_prdata,
  output logic                      s0_pready,
  output logic                      s0_pslverr,

  input  logic                      s1_psel,
  input  logic                      s1_penable,
  input  logic                      s1_pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] s1_paddr,
  input  logic [APB_DATA_WIDTH-1:0] s1_pwdata,
  output logic [APB_DATA_WIDTH-1:0] s1_prdata,
  output logic                      s1_pready,
  output logic                      s1_pslverr,

  output logic                      m_psel,
  output logic                      m_penable,
  output logic                      m_pwrite,
  output logic [APB_ADDR_WIDTH-1:0] m_paddr,
  output logic [APB_DATA_WIDTH-1:0] m_pwdata,
  input  logic [APB_DATA_WIDTH-1:0] m_prdata,
  input  logic                      m_pready,
  input  logic                      m_pslverr,

  output logic                      timeout_o
);

  localparam logic [TO_CNT_WIDTH-1:0] ToLimit = TO_CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                      ToEn    = (TIMEOUT_CYCLES != 0);

  arb_state_e                state_q, state_d;
  req_idx_t                  last_grant_q, last_grant_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                      pslverr_q, pslverr_d;
  logic [TO_CNT_WIDTH-1:0]   cnt_q, cnt_d;

  req_idx_t arb_idx;
  logic     arb_valid;

  // The arbiter ignores requester penable; it only needs psel to see a request.
  logic unused_penable;
  assign unused_penable = s0_penable ^ s1_penable;

  apb_rr_arbiter2 u_rr (
    .req_i       ({s1_psel, s0_psel}),
    .last_grant_i(last_grant_q),
    .gnt_idx_o   (arb_idx),
    .valid_o     (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    prdata_d     = prdata_q;
    pslverr_d    = pslverr_q;
    cnt_d        = cnt_q;
    timeout_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (arb_valid) begin
          last_grant_d = arb_idx;
          paddr_d      = arb_idx ? s1_paddr  : s0_paddr;
          pwrite_d     = arb_idx ? s1_pwrite : s0_pwrite;
          pwdata_d     = arb_idx ? s1_pwdata : s0_pwdata;
          state_d      = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (!m_pready) cnt_d = cnt_q + 1'b1;
        // A completion in the limit cycle takes priority over the abort.
        if (m_pready) begin
          prdata_d  = m_prdata;
          pslverr_d = m_pslverr;
          state_d   = StResp;
        end else if (ToEn && (cnt_q == ToLimit)) begin
          prdata_d  = APB_DATA_WIDTH'(TIMEOUT_RDATA);
          pslverr_d = 1'b1;
          timeout_o = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    m_psel     = (state_q == StSetup) || (state_q == StAccess);
    m_penable  = (state_q == StAccess);
    m_pwrite   = pwrite_q;
    m_paddr    = paddr_q;
    m_pwdata   = pwdata_q;
    s0_pready  = (state_q == StResp) && !last_grant_q;
    s1_pready  = (state_q == StResp) && last_grant_q;
    s0_prdata  = s0_pready ? prdata_q : '0;
    s1_prdata  = s1_pready ? prdata_q : '0;
    s0_pslverr = s0_pready && pslverr_q;
    s1_pslverr = s1_pready && pslverr_q;
  end

endmodule
